// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial BCD subtractor.
// Signal suffixes give the direction as seen from the subtractor.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);
    logic                  start_i;
    logic [4*DIGITS-1:0]   a_i;
    logic [4*DIGITS-1:0]   b_i;
    logic                  busy_o;
    logic                  done_o;
    logic [4*DIGITS-1:0]   d_o;
    logic                  neg_o;
    logic                  err_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, d_o, neg_o, err_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, d_o, neg_o, err_o
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor producing sign-magnitude |A-B|, LSD first.
// A final borrow triggers a second serial pass that ten's-complements the result.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    bcd_serial_subtractor_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    r_q;
    logic            borrow_q;
    logic [IW-1:0]   idx_q;
    logic            busy_q;
    logic            done_q;
    logic            neg_q;
    logic            err_q;
    logic [4:0]      step_d;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Returns {borrow_out, digit} for x - y - bw with decimal correction.
    function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y,
                                             input logic bw);
        logic [4:0] t;
        t = {1'b0, x} - {1'b0, y} - {4'd0, bw};
        if (t[4]) begin
            return {1'b1, t[3:0] + 4'd10};
        end else begin
            return {1'b0, t[3:0]};
        end
    endfunction

    // New digits enter at the top so the result lines up after DIGITS shifts.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
        logic [W-1:0] t;
        t = v >> 4'd4;
        t[W-1 -: 4] = d;
        return t;
    endfunction

    // Digit step shared by the subtract pass and the complement pass.
    always_comb begin
        step_d = 5'd0;
        if (state_q == COMP) begin
            step_d = digit_sub(4'd0, r_q[3:0], borrow_q);
        end else begin
            step_d = digit_sub(a_q[3:0], b_q[3:0], borrow_q);
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // busy_q still high here means this is the done cycle.
                    if (bus.start_i && !busy_q) begin
                        a_q      <= bus.a_i;
                        b_q      <= bus.b_i;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        neg_q    <= 1'b0;
                        err_q    <= 1'b0;
                        if (has_bad_digit(bus.a_i) || has_bad_digit(bus.b_i)) begin
                            err_q   <= 1'b1;
                            r_q     <= '0;
                            state_q <= DONE;
                        end else begin
                            state_q <= SUB;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SUB: begin
                    r_q <= shift_in(r_q, step_d[3:0]);
                    a_q <= a_q >> 4'd4;
                    b_q <= b_q >> 4'd4;
                    if (idx_q == LAST_IDX) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        if (step_d[4]) begin
                            state_q <= COMP;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= step_d[4];
                    end
                end
                COMP: begin
                    r_q <= shift_in(r_q, step_d[3:0]);
                    if (idx_q == LAST_IDX) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        neg_q    <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= step_d[4];
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.d_o    = r_q;
    assign bus.neg_o  = neg_q;
    assign bus.err_o  = err_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed-vector bench for the 4-digit serial BCD subtractor.
module tb_bcd_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulses start at a negedge, scrambles inputs after the accepting edge and
    // returns the number of clocks until done is seen (0 on timeout).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        bus.a_i = a;
        bus.b_i = b;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i = 16'h5555;
        bus.b_i = 16'h6A6A;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.neg_o, bus.err_o} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.busy_o, bus.done_o, bus.neg_o, bus.err_o});
        end
        n_cmp++;
        if (bus.d_o !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_d: got %h want 0000", bus.d_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_result(input string name, input int lat, input int lat_exp,
                                input logic [15:0] d_exp, input logic neg_exp,
                                input logic err_exp);
        n_cmp++;
        if (lat !== lat_exp) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, lat_exp);
        end
        n_cmp++;
        if ({bus.d_o, bus.neg_o, bus.err_o, bus.busy_o} !== {d_exp, neg_exp, err_exp, 1'b1}) begin
            n_bad++;
            $display("FAIL %s_result: got d=%h neg=%b err=%b busy=%b want d=%h neg=%b err=%b busy=1",
                     name, bus.d_o, bus.neg_o, bus.err_o, bus.busy_o, d_exp, neg_exp, err_exp);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.done_o, bus.busy_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s_after_done: got done=%b busy=%b want 0 0",
                     name, bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_sub_pos();
        int lat;
        do_op(16'h0042, 16'h0017, lat);
        check_result("pos_42_17", lat, 5, 16'h0025, 1'b0, 1'b0);
        do_op(16'h1000, 16'h0001, lat);
        check_result("pos_1000_1", lat, 5, 16'h0999, 1'b0, 1'b0);
    endtask

    task automatic test_sub_neg();
        int lat;
        do_op(16'h0017, 16'h0042, lat);
        check_result("neg_17_42", lat, 9, 16'h0025, 1'b1, 1'b0);
        do_op(16'h0000, 16'h9999, lat);
        check_result("neg_0_9999", lat, 9, 16'h9999, 1'b1, 1'b0);
    endtask

    task automatic test_boundaries();
        int lat;
        do_op(16'h1234, 16'h1234, lat);
        check_result("equal", lat, 5, 16'h0000, 1'b0, 1'b0);
        do_op(16'h9999, 16'h0000, lat);
        check_result("max_minus_0", lat, 5, 16'h9999, 1'b0, 1'b0);
    endtask

    task automatic test_err();
        int lat;
        do_op(16'h0017, 16'h0042, lat);
        check_result("pre_err_neg", lat, 9, 16'h0025, 1'b1, 1'b0);
        do_op(16'h00A1, 16'h0003, lat);
        check_result("err_a", lat, 1, 16'h0000, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL err_hold: got %b want 1", bus.err_o);
        end
        do_op(16'h0005, 16'h0003, lat);
        check_result("post_err", lat, 5, 16'h0002, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.a_i = 16'h0017;
        bus.b_i = 16'h0042;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy: got %b want 1", bus.busy_o);
        end
        bus.a_i = 16'h0001;
        bus.b_i = 16'h0000;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if ({bus.d_o, bus.neg_o} !== {16'h0025, 1'b1} || lat != 9) begin
            n_bad++;
            $display("FAIL b2b_ignored: got d=%h neg=%b lat=%0d want d=0025 neg=1 lat=9",
                     bus.d_o, bus.neg_o, lat);
        end
        bus.a_i = 16'h0300;
        bus.b_i = 16'h0100;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.done_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL done_cycle_start: got busy=%b done=%b want 0 0",
                     bus.busy_o, bus.done_o);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.d_o, bus.neg_o} !== {1'b0, 16'h0025, 1'b1}) begin
            n_bad++;
            $display("FAIL done_cycle_hold: got busy=%b d=%h neg=%b want 0 0025 1",
                     bus.busy_o, bus.d_o, bus.neg_o);
        end
    endtask

    task automatic test_rst_abort();
        int lat;
        int seen;
        bus.a_i = 16'h0042;
        bus.b_i = 16'h0017;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.neg_o, bus.err_o, bus.d_o} !== 20'h00000) begin
            n_bad++;
            $display("FAIL abort_clear: got busy=%b done=%b neg=%b err=%b d=%h want all 0",
                     bus.busy_o, bus.done_o, bus.neg_o, bus.err_o, bus.d_o);
        end
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) begin
                seen++;
            end
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        do_op(16'h1000, 16'h0001, lat);
        check_result("after_abort", lat, 5, 16'h0999, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.a_i = 16'h0000;
        bus.b_i = 16'h0000;
        test_reset();
        test_sub_pos();
        test_sub_neg();
        test_boundaries();
        test_err();
        test_back_to_back();
        test_sub_neg();
        test_rst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
